// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchronizer plus four-state debounce qualifier for a raw pad input
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             s;

  assign s = sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Only sync1 looks at the raw pin; everything downstream sees s.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy  = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    level = level_q;
    rise  = rise_q;
    fall  = fall_q;
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - randomized and directed bench for debounce_sync against a run-length reference model
module tb_debounce_sync;

  localparam int D = 4;

  logic clk;
  logic reset;
  logic din;
  logic level, rise, fall, busy;

  int checks;
  int failures;

  // Reference model: s lags din by two edges; k counts consecutive edges with s != accepted level.
  logic m_h0, m_h1;
  logic m_level, m_rise, m_fall;
  int   m_k;
  logic [3:0] exp_v;
  logic [3:0] got_v;

  debounce_sync #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    logic s;
    @(posedge clk);
    if (!reset) begin
      m_h0 = 1'b0; m_h1 = 1'b0;
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_k = 0;
    end else begin
      s = m_h1;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s == m_level) begin
        m_k = 0;
      end else if (m_k == D) begin
        m_level = s;
        m_rise  = s;
        m_fall  = !s;
        m_k     = 0;
      end else begin
        m_k = m_k + 1;
      end
      m_h1 = m_h0;
      m_h0 = din;
    end
    #1;
    exp_v = {m_level, m_rise, m_fall, (m_k != 0)};
    got_v = {level, rise, fall, busy};
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    din   = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    din   = 1'($urandom);
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if (got_v !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold edge=%0d got=%b exp=0000", n, got_v);
      end
    end
    reset = 1'b1;
    din   = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (got_v !== 4'b0000 || got_v !== exp_v) begin
        failures++;
        $display("FAIL idle_low edge=%0d got=%b exp=0000 model=%b", n, got_v, exp_v);
      end
    end
  endtask

  task automatic test_rise_latency();
    logic [3:0] want;
    apply_reset();
    din = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      want = {n >= 7, n == 7, 1'b0, (n >= 3 && n < 7)};
      checks++;
      if (got_v !== want || got_v !== exp_v) begin
        failures++;
        $display("FAIL rise_latency edge=%0d got=%b exp=%b model=%b", n, got_v, want, exp_v);
      end
    end
  endtask

  task automatic test_fall_latency();
    logic [3:0] want;
    din = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      want = {n < 7, 1'b0, n == 7, (n >= 3 && n < 7)};
      checks++;
      if (got_v !== want || got_v !== exp_v) begin
        failures++;
        $display("FAIL fall_latency edge=%0d got=%b exp=%b model=%b", n, got_v, want, exp_v);
      end
    end
  endtask

  task automatic test_short_pulse();
    int rises, busy_seen, level_seen;
    rises = 0; busy_seen = 0; level_seen = 0;
    apply_reset();
    din = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n == 4) din = 1'b0;
      tick();
      rises += int'(rise);
      busy_seen += int'(busy);
      level_seen += int'(level);
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL short_pulse_model edge=%0d got=%b exp=%b", n, got_v, exp_v);
      end
    end
    checks++;
    if (rises != 0 || level_seen != 0 || busy_seen == 0) begin
      failures++;
      $display("FAIL short_pulse rises=%0d level_cycles=%0d busy_cycles=%0d exp rises=0 level_cycles=0 busy_cycles>0",
               rises, level_seen, busy_seen);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int rises, rise_edge;
    pat = 4'b0101;
    rises = 0; rise_edge = -1;
    apply_reset();
    for (int n = 1; n <= 16; n++) begin
      din = (n <= 4) ? pat[n-1] : 1'b1;
      tick();
      if (rise) begin
        rises++;
        rise_edge = n;
      end
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL bounce_model edge=%0d got=%b exp=%b", n, got_v, exp_v);
      end
    end
    checks++;
    if (rises != 1 || rise_edge != 11) begin
      failures++;
      $display("FAIL bounce_rise count=%0d edge=%0d exp count=1 edge=11", rises, rise_edge);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    apply_reset();
    din = 1'b1;
    repeat (6) tick();
    checks++;
    if (got_v !== 4'b0001) begin
      failures++;
      $display("FAIL pre_reset_wait got=%b exp=0001", got_v);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (got_v !== 4'b0000) begin
      failures++;
      $display("FAIL reset_override got=%b exp=0000", got_v);
    end
    reset = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      want = {n >= 7, n == 7, 1'b0, (n >= 3 && n < 7)};
      checks++;
      if (got_v !== want || got_v !== exp_v) begin
        failures++;
        $display("FAIL requalify edge=%0d got=%b exp=%b model=%b", n, got_v, want, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int run_left;
    int model_rises, dut_rises;
    model_rises = 0; dut_rises = 0;
    apply_reset();
    run_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        din = 1'($urandom);
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 5);
      end
      run_left--;
      reset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      tick();
      model_rises += int'(m_rise);
      dut_rises   += int'(rise);
      checks++;
      if (got_v !== exp_v || (rise && fall)) begin
        failures++;
        $display("FAIL random cycle=%0d got=%b exp=%b", n, got_v, exp_v);
      end
    end
    reset = 1'b1;
    checks++;
    if (dut_rises != model_rises || model_rises == 0) begin
      failures++;
      $display("FAIL random_rise_total got=%0d exp=%0d", dut_rises, model_rises);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    din = 1'b0;
    m_h0 = 1'b0; m_h1 = 1'b0;
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_k = 0;
    test_reset();
    test_rise_latency();
    test_fall_latency();
    test_short_pulse();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
